// File: rtl/cpu_switch_sequencer_if.sv
// Request/status bundle between the OSD/core glue and cpu_switch_sequencer.
// master: the side that issues CPU selection / reset requests and sees vblank.
// slave:  the sequencer itself.
interface cpu_switch_sequencer_if;
    logic [1:0] cpu_type_req;
    logic       rst_req;
    logic       vblank;
    logic [1:0] cpu_sel;
    logic [3:0] core_n_reset;
    logic [3:0] core_clk_en;
    logic       busy;
    logic       video_mute;

    modport master (
        output cpu_type_req, rst_req, vblank,
        input  cpu_sel, core_n_reset, core_clk_en, busy, video_mute
    );

    modport slave (
        input  cpu_type_req, rst_req, vblank,
        output cpu_sel, core_n_reset, core_clk_en, busy, video_mute
    );
endinterface

// File: rtl/cpu_switch_sequencer.sv
// CPU switch sequencer: debounces the OSD core selection, waits for the active
// core's vblank (or a timeout), then holds the newly selected core in reset.
// Optional macro SWITCH_MUTE_EN: force-blank video through reset and for
// MUTE_FRAMES vblanks after release; without it video_mute is tied low.
module cpu_switch_sequencer #(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned DRAIN_TIMEOUT = 1000000,
    parameter int unsigned HOLD_CYCLES   = 65536,
    parameter int unsigned MUTE_FRAMES   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu_switch_sequencer_if.slave   bus
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES   > 1 ? HOLD_CYCLES   : 2);
    localparam int unsigned SW = $clog2(STABLE_CYCLES > 1 ? STABLE_CYCLES : 2);
    localparam int unsigned DW = $clog2(DRAIN_TIMEOUT > 1 ? DRAIN_TIMEOUT : 2);

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

`ifdef SWITCH_MUTE_EN
    localparam logic MUTE_RST = 1'b1;
`else
    localparam logic MUTE_RST = 1'b0;
`endif

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_STABILIZE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    cand_q, cand_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          vblank_q;
    logic          vb_rise;

    logic [3:0]    n_reset_q, n_reset_d;
    logic [3:0]    clk_en_q, clk_en_d;
    logic          busy_q, busy_d;
    logic          mute_q, mute_d;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    assign vb_rise = bus.vblank & ~vblank_q;

    // Previous vblank sample for rising-edge detection.
    always_ff @(posedge clk) begin
        vblank_q <= bus.vblank;
    end

    // Next-state logic; outputs are decoded from the next state so they move with it.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cand_d  = cand_q;
        hold_d  = hold_q;
        stab_d  = stab_q;
        drain_d = drain_q;

        unique case (state_q)
            S_HOLD: begin
                if (bus.rst_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.rst_req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end else if (bus.cpu_type_req != sel_q) begin
                    state_d = S_STABILIZE;
                    cand_d  = bus.cpu_type_req;
                    stab_d  = '0;
                end
            end
            S_STABILIZE: begin
                if (bus.rst_req) begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end else if (bus.cpu_type_req == sel_q) begin
                    state_d = S_RUN;
                end else if (bus.cpu_type_req != cand_q) begin
                    cand_d = bus.cpu_type_req;
                    stab_d = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // rst_req also commits: the pending selection is taken with the reset.
                if (vb_rise || bus.rst_req || drain_q == DRAIN_LAST) begin
                    sel_d   = cand_q;
                    state_d = S_HOLD;
                    hold_d  = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
                hold_d  = '0;
            end
        endcase

        clk_en_d  = onehot(sel_d);
        n_reset_d = (state_d == S_HOLD) ? 4'b0000 : onehot(sel_d);
        busy_d    = (state_d != S_RUN);
    end

`ifdef SWITCH_MUTE_EN
    localparam int unsigned FW = $clog2(MUTE_FRAMES + 2);
    localparam logic [FW-1:0] FRAMES_DONE = FW'(MUTE_FRAMES);

    logic [FW-1:0] frame_q, frame_d;

    // Count vblank rising edges since release; any reset hold clears the count.
    always_comb begin
        frame_d = frame_q;
        if (state_d == S_HOLD) begin
            frame_d = '0;
        end else if (state_q != S_HOLD && vb_rise && frame_q != FRAMES_DONE) begin
            frame_d = frame_q + 1'b1;
        end
        mute_d = (state_d == S_HOLD) || (frame_d != FRAMES_DONE);
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end
`else
    assign mute_d = 1'b0;
`endif

    // State, counters and registered outputs; reset adopts the requested core directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_HOLD;
            sel_q     <= bus.cpu_type_req;
            cand_q    <= '0;
            hold_q    <= '0;
            stab_q    <= '0;
            drain_q   <= '0;
            n_reset_q <= 4'b0000;
            clk_en_q  <= onehot(bus.cpu_type_req);
            busy_q    <= 1'b1;
            mute_q    <= MUTE_RST;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cand_q    <= cand_d;
            hold_q    <= hold_d;
            stab_q    <= stab_d;
            drain_q   <= drain_d;
            n_reset_q <= n_reset_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
            mute_q    <= mute_d;
        end
    end

    assign bus.cpu_sel      = sel_q;
    assign bus.core_n_reset = n_reset_q;
    assign bus.core_clk_en  = clk_en_q;
    assign bus.busy         = busy_q;
    assign bus.video_mute   = mute_q;

endmodule

// File: tb/tb_cpu_switch_sequencer.sv
// Directed bench for cpu_switch_sequencer with small timing parameters.
// Each step drives inputs, pushes the outputs expected after the next clock
// edge into a scoreboard queue, then pops and compares them after that edge.
module tb_cpu_switch_sequencer;

`ifdef SWITCH_MUTE_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [11:0] exp;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    sb_entry_t sb_q[$];

    cpu_switch_sequencer_if bus ();

    cpu_switch_sequencer #(
        .STABLE_CYCLES (4),
        .DRAIN_TIMEOUT (16),
        .HOLD_CYCLES   (8),
        .MUTE_FRAMES   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input logic [1:0] s);
        logic [3:0] v;
        v = 4'b0001;
        return v << s;
    endfunction

    // rs/req/rr/vb: inputs for the coming edge; esel/nrst_on/ebusy/emute: outputs after it.
    task automatic step(input logic rs, input logic [1:0] req, input logic rr, input logic vb,
                        input logic [1:0] esel, input logic nrst_on, input logic ebusy,
                        input logic emute, input string tag, input int unsigned n = 1);
        sb_entry_t e, got;
        logic [11:0] obs;
        for (int unsigned i = 0; i < n; i++) begin
            reset            = rs;
            bus.cpu_type_req = req;
            bus.rst_req      = rr;
            bus.vblank       = vb;
            e.tag = tag;
            e.exp = {esel, (nrst_on ? oh(esel) : 4'b0000), oh(esel), ebusy, emute & FEAT};
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            got = sb_q.pop_front();
            obs = {bus.cpu_sel, bus.core_n_reset, bus.core_clk_en, bus.busy, bus.video_mute};
            n_checks++;
            assert (obs === got.exp) else begin
                n_errors++;
                $error("FAIL %s[%0d]: observed {sel,nrst,clken,busy,mute}=%b expected=%b",
                       got.tag, i, obs, got.exp);
            end
        end
    endtask

    // nh further cycles in reset hold, then the release cycle (mute still pending).
    task automatic hold_release(input logic [1:0] sel, input int unsigned nh);
        step(0, sel, 0, 0, sel, 0, 1, 1, "hold", nh);
        step(0, sel, 0, 0, sel, 1, 0, 1, "release");
    endtask

    // Two vblank rising edges in RUN; mute drops on the second.
    task automatic clear_mute(input logic [1:0] sel);
        step(0, sel, 0, 1, sel, 1, 0, 1, "mute_vb1");
        step(0, sel, 0, 0, sel, 1, 0, 1, "mute_vb1_low");
        step(0, sel, 0, 1, sel, 1, 0, 0, "mute_vb2");
        step(0, sel, 0, 0, sel, 1, 0, 0, "mute_off");
    endtask

    initial begin
        reset            = 1'b1;
        bus.cpu_type_req = 2'd2;
        bus.rst_req      = 1'b0;
        bus.vblank       = 1'b0;

        // Power-up with core 2 requested.
        step(1, 2, 0, 0, 2, 0, 1, 1, "reset", 3);
        hold_release(2, 7);
        clear_mute(2);

        // Switch to core 1 with no vblank: commit on the drain timeout.
        step(0, 1, 0, 0, 2, 1, 1, 0, "to1_stab", 5);
        step(0, 1, 0, 0, 2, 1, 1, 0, "to1_drain", 15);
        step(0, 1, 0, 0, 1, 0, 1, 1, "to1_timeout_commit");
        hold_release(1, 7);
        clear_mute(1);

        // Switch to core 0, committed by a vblank rising edge.
        step(0, 0, 0, 0, 1, 1, 1, 0, "to0_stab", 5);
        step(0, 0, 0, 1, 0, 0, 1, 1, "to0_vb_commit");
        hold_release(0, 7);
        clear_mute(0);

        // Brief request for core 2 then back: aborted, no reset pulse.
        step(0, 2, 0, 0, 0, 1, 1, 0, "abort_stab", 3);
        step(0, 0, 0, 0, 0, 1, 0, 0, "abort_run", 3);

        // Request 1 briefly, then 3 held; vblank rises 10 cycles after 3 appears.
        step(0, 1, 0, 0, 0, 1, 1, 0, "to3_req1", 2);
        step(0, 3, 0, 0, 0, 1, 1, 0, "to3_wait", 9);
        step(0, 3, 0, 1, 3, 0, 1, 1, "to3_vb_commit");
        hold_release(3, 7);
        clear_mute(3);

        // Vblank rise coincides with the drain timeout: one commit only.
        step(0, 2, 0, 0, 3, 1, 1, 0, "sim_stab", 5);
        step(0, 2, 0, 0, 3, 1, 1, 0, "sim_drain", 15);
        step(0, 2, 0, 1, 2, 0, 1, 1, "sim_commit");
        step(0, 2, 0, 1, 2, 0, 1, 1, "sim_single");
        hold_release(2, 6);
        clear_mute(2);

        // User reset: one-cycle pulse, then a 20-cycle hold.
        step(0, 2, 1, 0, 2, 0, 1, 1, "rst_pulse");
        hold_release(2, 7);
        step(0, 2, 1, 0, 2, 0, 1, 1, "rst_held", 20);
        hold_release(2, 7);

        // Block reset mid-switch discards the pending candidate.
        step(0, 1, 0, 0, 2, 1, 1, 1, "mid_stab", 3);
        step(1, 0, 0, 0, 0, 0, 1, 1, "mid_reset");
        hold_release(0, 7);
        step(0, 0, 0, 0, 0, 1, 0, 1, "mid_no_pending", 3);

        // User reset during drain commits the candidate.
        step(0, 3, 0, 0, 0, 1, 1, 1, "rd_stab", 5);
        step(0, 3, 0, 0, 0, 1, 1, 1, "rd_drain", 2);
        step(0, 3, 1, 0, 3, 0, 1, 1, "rd_commit");
        hold_release(3, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_switch_sequencer.md
Name: cpu_switch_sequencer

Overview:
Sits directly upstream of the four microcomputer cores and the video/SD output mux in the emu top level. Turns the raw OSD CPU selection and the user reset request into clean per-core reset and clock-enable controls plus a registered mux select. A selection change is debounced, synchronised to the active core's vertical blank, and followed by a fixed reset hold on the new core. This prevents partial frames, torn SD transactions and half-reset cores while the user scrolls through the OSD menu.

Parameters:
STABLE_CYCLES, 50000, cycles cpu_type_req must stay constant before a switch is accepted (1 ms at 50 MHz).
DRAIN_TIMEOUT, 1000000, maximum cycles to wait for a vblank rising edge before forcing the switch.
HOLD_CYCLES, 65536, cycles the selected core is held in reset.
MUTE_FRAMES, 2, vblank rising edges after release during which video stays muted (used only with the optional feature).

Ports:
clk  in  1  system clock (CLK_50M domain)
reset  in  1  synchronous, active-high block reset
cpu_type_req  in  2  requested core: 0 Z80-CP/M, 1 6502-Basic, 2 6809-Basic, 3 6809-Forth
rst_req  in  1  user reset request, level
vblank  in  1  vblank of the currently selected core (post-mux)
cpu_sel  out  2  registered select for the output mux
core_n_reset  out  4  per-core active-low reset; bit i is core i
core_clk_en  out  4  per-core clock enable, one-hot
busy  out  1  high in every state except RUN
video_mute  out  1  force-blank request to the video stage

Behaviour:
- All outputs are registered and decoded from the next state, so they change in the same cycle as the state register.
- Internal state: vblank_q (previous vblank); vb_rise = vblank & ~vblank_q.
- Counters are sized by $clog2 of their parameter and saturate; they never wrap.

Reset (while reset=1):
- cpu_sel <= cpu_type_req; state <= HOLD; hold counter <= 0.
- core_n_reset = 0000; core_clk_en = onehot(cpu_type_req); busy = 1.
- video_mute = 1 with the feature, 0 without.

States:
- HOLD:
  - core_n_reset = 0000; core_clk_en = onehot(cpu_sel); busy = 1.
  - Counts to HOLD_CYCLES-1, then goes to RUN.
  - rst_req=1 clears the counter, so release comes HOLD_CYCLES cycles after rst_req falls.
- RUN:
  - core_n_reset = onehot(cpu_sel); core_clk_en = onehot(cpu_sel); busy = 0.
  - Priority 1: rst_req → HOLD (counter 0, cpu_sel unchanged).
  - Priority 2: cpu_type_req != cpu_sel → STABILIZE, with cand <= cpu_type_req and stab counter 0.
- STABILIZE:
  - Active core keeps running; outputs as in RUN except busy = 1.
  - Checks in priority order:
    1. rst_req → HOLD.
    2. cpu_type_req == cpu_sel → RUN (aborted; no reset pulse).
    3. cpu_type_req != cand → relatch cand and clear the counter.
    4. Counter reaches STABLE_CYCLES-1 → DRAIN with drain counter 0.
- DRAIN:
  - Outputs as in STABILIZE.
  - vb_rise, drain counter reaching DRAIN_TIMEOUT-1, or rst_req triggers a commit.
  - Commit: cpu_sel <= cand; go to HOLD with counter 0.
  - A cpu_type_req change during DRAIN is ignored; it is re-detected in RUN.
- Boundary rules:
  - Simultaneous vb_rise and timeout is a single commit.
  - reset mid-switch discards cand and the counters.
  - Exactly one core_clk_en bit is ever set.
  - A non-selected core never sees core_n_reset=1.

Optional Feature:
Macro SWITCH_MUTE_EN.
- Defined:
  - video_mute = 1 from reset and from every HOLD entry.
  - On RUN entry a frame counter clears and counts vb_rise; video_mute falls in the cycle the MUTE_FRAMES-th vb_rise is counted.
  - Re-entering HOLD re-asserts video_mute immediately.
- Undefined: video_mute is tied 0; the frame counter is not built.

Test Plan:
Use parameters STABLE_CYCLES=4, HOLD_CYCLES=8, DRAIN_TIMEOUT=16, MUTE_FRAMES=2.
1. Reset high for 3 cycles with cpu_type_req=2, then release → cpu_sel=2, core_clk_en=0100 throughout, core_n_reset=0000 for 8 cycles then 0100, busy falls with it.
2. In RUN with sel=0: req=1 for 2 cycles, then 3 held; vblank rises 10 cycles later → no reset pulse before the commit; at vb_rise cpu_sel=3, core_n_reset=0000 for 8 cycles, then 1000, core_clk_en=1000.
3. In RUN with sel=0: req=2 for 3 cycles, then back to 0 → returns to RUN; core_n_reset stays 0001 and cpu_sel stays 0 the whole time.
4. Switch to 1 with vblank held 0 → commit occurs exactly 16 cycles after DRAIN entry; cpu_sel=1.
5. In RUN: rst_req pulses 1 cycle → core_n_reset=0000 for 8 cycles, cpu_sel unchanged. rst_req held 20 cycles → release 8 cycles after rst_req falls.
6. Feature: with SWITCH_MUTE_EN, video_mute=1 through HOLD and until the 2nd vb_rise in RUN. Without it, video_mute=0 in every scenario above.
